// File: rtl/cnn_argmax_out_if.sv
// Result channel of the CNN argmax stage: class index, max score and flags under valid/ready.
interface cnn_argmax_out_if #(
  parameter int unsigned DATA_W = 13,
  parameter int unsigned IDX_W  = 3
);
  logic              valid;
  logic              ready;
  logic [IDX_W-1:0]  class_idx;
  logic [DATA_W-1:0] max_val;
  logic [DATA_W-1:0] max_relu;
  logic              all_neg;

  modport master (
    output valid,
    output class_idx,
    output max_val,
    output max_relu,
    output all_neg,
    input  ready
  );

  modport slave (
    input  valid,
    input  class_idx,
    input  max_val,
    input  max_relu,
    input  all_neg,
    output ready
  );
endinterface

// File: rtl/cnn_argmax_out.sv
// Argmax classifier behind the CNN core: captures the final-layer scores on a rising done,
// scans them one per cycle for the signed maximum and holds the result under valid/ready.
module cnn_argmax_out #(
  parameter int unsigned N_IN   = 5,
  parameter int unsigned DATA_W = 13,
  parameter int unsigned IDX_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*DATA_W-1:0] in_scores,
  input  logic                   in_done,
  cnn_argmax_out_if.master       res,
  output logic                   overrun,
  output logic [7:0]             frame_cnt
);

  typedef enum logic [1:0] {StIdle, StScan, StHold} state_e;

  localparam logic signed [DATA_W-1:0] MinVal  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]         LastIdx = IDX_W'(N_IN - 1);

  state_e                    state_q;
  logic                      done_q;
  logic signed [DATA_W-1:0]  score_q [N_IN];
  logic [IDX_W-1:0]          idx_q;
  logic [IDX_W-1:0]          best_idx_q;
  logic signed [DATA_W-1:0]  best_q;
  logic                      all_neg_q;

  logic                      done_rise;
  logic                      handshake;
  logic signed [DATA_W-1:0]  cur_score;
  logic                      take;
  logic signed [DATA_W-1:0]  best_d;
  logic [IDX_W-1:0]          best_idx_d;
  logic                      all_neg_d;

  assign done_rise = in_done & ~done_q;
  assign handshake = res.valid & res.ready;

  // Strict greater-than keeps the lower index on ties.
  always_comb begin
    cur_score  = score_q[idx_q];
    take       = cur_score > best_q;
    best_d     = take ? cur_score : best_q;
    best_idx_d = take ? idx_q : best_idx_q;
    all_neg_d  = all_neg_q & cur_score[DATA_W-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      // Start high so a done level held through reset release is not seen as an edge.
      done_q        <= 1'b1;
      for (int i = 0; i < int'(N_IN); i++) begin
        score_q[i] <= '0;
      end
      idx_q         <= '0;
      best_idx_q    <= '0;
      best_q        <= MinVal;
      all_neg_q     <= 1'b1;
      res.valid     <= 1'b0;
      res.class_idx <= '0;
      res.max_val   <= '0;
      res.max_relu  <= '0;
      res.all_neg   <= 1'b0;
      overrun       <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      done_q <= in_done;
      unique case (state_q)
        StIdle: begin
          if (done_rise) begin
            for (int i = 0; i < int'(N_IN); i++) begin
              score_q[i] <= in_scores[i*DATA_W +: DATA_W];
            end
            idx_q      <= '0;
            best_idx_q <= '0;
            best_q     <= MinVal;
            all_neg_q  <= 1'b1;
            state_q    <= StScan;
          end
        end
        StScan: begin
          if (done_rise) begin
            overrun <= 1'b1;
          end
          best_q     <= best_d;
          best_idx_q <= best_idx_d;
          all_neg_q  <= all_neg_d;
          idx_q      <= idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            res.valid     <= 1'b1;
            res.class_idx <= best_idx_d;
            res.max_val   <= best_d;
            res.max_relu  <= best_d[DATA_W-1] ? '0 : best_d;
            res.all_neg   <= all_neg_d;
            state_q       <= StHold;
          end
        end
        StHold: begin
          if (handshake) begin
            res.valid <= 1'b0;
            frame_cnt <= frame_cnt + 8'd1;
            state_q   <= StIdle;
            // A new frame arriving on the handshake cycle is accepted, not dropped.
            if (done_rise) begin
              for (int i = 0; i < int'(N_IN); i++) begin
                score_q[i] <= in_scores[i*DATA_W +: DATA_W];
              end
              idx_q      <= '0;
              best_idx_q <= '0;
              best_q     <= MinVal;
              all_neg_q  <= 1'b1;
              state_q    <= StScan;
            end
          end else if (done_rise) begin
            overrun <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_argmax_out.sv
// Directed bench for cnn_argmax_out: latency, argmax/tie/sign cases, backpressure and reset.
module tb_cnn_argmax_out;
  localparam int unsigned N_IN   = 5;
  localparam int unsigned DATA_W = 13;
  localparam int unsigned IDX_W  = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_IN*DATA_W-1:0] in_scores;
  logic                   in_done;
  logic                   overrun;
  logic [7:0]             frame_cnt;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_cnt  = 8'd0;

  cnn_argmax_out_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) res_if ();

  cnn_argmax_out #(.N_IN(N_IN), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_scores (in_scores),
    .in_done   (in_done),
    .res       (res_if),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_scores(input logic [12:0] s0, input logic [12:0] s1, input logic [12:0] s2,
                            input logic [12:0] s3, input logic [12:0] s4);
    in_scores = {s4, s3, s2, s1, s0};
  endtask

  // Capture at E0, valid must appear after E5 (not E4), then one handshake.
  task automatic run_frame(input string name,
                           input logic [12:0] s0, input logic [12:0] s1, input logic [12:0] s2,
                           input logic [12:0] s3, input logic [12:0] s4,
                           input logic [2:0] e_cls, input logic [12:0] e_max,
                           input logic [12:0] e_relu, input logic e_neg);
    set_scores(s0, s1, s2, s3, s4);
    in_done     = 1'b1;
    res_if.ready = 1'b0;
    @(negedge clk);
    in_done   = 1'b0;
    in_scores = 65'({$urandom(), $urandom(), $urandom()});
    repeat (4) @(negedge clk);
    check({name, ".valid_early"}, 32'(res_if.valid), 32'd0);
    @(negedge clk);
    check({name, ".valid"}, 32'(res_if.valid), 32'd1);
    check({name, ".class"}, 32'(res_if.class_idx), 32'(e_cls));
    check({name, ".max"}, 32'(res_if.max_val), 32'(e_max));
    check({name, ".relu"}, 32'(res_if.max_relu), 32'(e_relu));
    check({name, ".all_neg"}, 32'(res_if.all_neg), 32'(e_neg));
    res_if.ready = 1'b1;
    @(negedge clk);
    exp_cnt = exp_cnt + 8'd1;
    check({name, ".valid_after_hs"}, 32'(res_if.valid), 32'd0);
    check({name, ".frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    res_if.ready = 1'b0;
  endtask

  initial begin
    rst          = 1'b0;
    in_done      = 1'b0;
    in_scores    = '0;
    res_if.ready = 1'b0;
    #1;
    check("rst.valid", 32'(res_if.valid), 32'd0);
    check("rst.class", 32'(res_if.class_idx), 32'd0);
    check("rst.max", 32'(res_if.max_val), 32'd0);
    check("rst.relu", 32'(res_if.max_relu), 32'd0);
    check("rst.all_neg", 32'(res_if.all_neg), 32'd0);
    check("rst.overrun", 32'(overrun), 32'd0);
    check("rst.frame_cnt", 32'(frame_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_frame("basic", 13'd10, 13'd200, 13'd50, 13'd199, 13'd3, 3'd1, 13'd200, 13'd200, 1'b0);
    run_frame("ties", 13'd100, 13'd300, 13'd300, 13'd7, 13'd0, 3'd1, 13'd300, 13'd300, 1'b0);
    run_frame("neg", -13'sd5, -13'sd1, -13'sd100, -13'sd4096, -13'sd2,
              3'd1, 13'h1FFF, 13'd0, 1'b1);
    run_frame("extreme", 13'h1000, 13'h1000, 13'h1000, 13'h1000, 13'd4095,
              3'd4, 13'd4095, 13'd4095, 1'b0);
    run_frame("allmin", 13'h1000, 13'h1000, 13'h1000, 13'h1000, 13'h1000,
              3'd0, 13'h1000, 13'd0, 1'b1);
    check("pre_bp.overrun", 32'(overrun), 32'd0);

    // Backpressure: hold the result while in_done re-pulses.
    set_scores(13'd1, 13'd2, 13'd3, 13'd4, 13'd5);
    in_done = 1'b1;
    @(negedge clk);
    in_done = 1'b0;
    repeat (5) @(negedge clk);
    check("bp.valid", 32'(res_if.valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_done = 1'b1;
        set_scores(13'd500, 13'd0, 13'd0, 13'd0, 13'd0);
      end
      if (i == 5) in_done = 1'b0;
      @(negedge clk);
    end
    check("bp.valid_held", 32'(res_if.valid), 32'd1);
    check("bp.class_held", 32'(res_if.class_idx), 32'd4);
    check("bp.max_held", 32'(res_if.max_val), 32'd5);
    check("bp.overrun", 32'(overrun), 32'd1);
    check("bp.frame_cnt_held", 32'(frame_cnt), 32'(exp_cnt));

    // Handshake and new done edge on the same clock.
    set_scores(-13'sd3, 13'd9, 13'd9, -13'sd1, 13'd2);
    res_if.ready = 1'b1;
    in_done      = 1'b1;
    @(negedge clk);
    exp_cnt = exp_cnt + 8'd1;
    res_if.ready = 1'b0;
    in_done      = 1'b0;
    check("hs_edge.valid", 32'(res_if.valid), 32'd0);
    check("hs_edge.frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    repeat (4) @(negedge clk);
    check("hs_edge.valid_early", 32'(res_if.valid), 32'd0);
    @(negedge clk);
    check("hs_edge.valid2", 32'(res_if.valid), 32'd1);
    check("hs_edge.class", 32'(res_if.class_idx), 32'd1);
    check("hs_edge.max", 32'(res_if.max_val), 32'd9);
    check("hs_edge.overrun", 32'(overrun), 32'd1);
    check("hs_edge.frame_cnt2", 32'(frame_cnt), 32'(exp_cnt));
    res_if.ready = 1'b1;
    @(negedge clk);
    exp_cnt = exp_cnt + 8'd1;
    res_if.ready = 1'b0;
    check("hs2.frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

    // Reset mid-scan with in_done held high through release.
    set_scores(13'd7, 13'd8, 13'd9, 13'd10, 13'd11);
    in_done = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst.valid", 32'(res_if.valid), 32'd0);
    check("mid_rst.max", 32'(res_if.max_val), 32'd0);
    check("mid_rst.class", 32'(res_if.class_idx), 32'd0);
    check("mid_rst.overrun", 32'(overrun), 32'd0);
    check("mid_rst.frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst.no_capture", 32'(res_if.valid), 32'd0);
    check("post_rst.max", 32'(res_if.max_val), 32'd0);
    in_done = 1'b0;
    @(negedge clk);
    exp_cnt = 8'd0;
    run_frame("zeros", 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 3'd0, 13'd0, 13'd0, 1'b0);
    check("final.overrun", 32'(overrun), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cnn_argmax_out.md
Name: cnn_argmax_out

Overview:
- Downstream classifier stage for the CNN core.
- Waits for the core's `done` to rise, then captures the N_IN final-layer scores (13-bit, two's complement).
- Scans the scores sequentially to find the signed maximum and its index.
- Presents class index, raw max score and ReLU'd max score to the consumer, holding them under a valid/ready handshake.

Parameters:
- N_IN, 5, number of score inputs (CNN output channels); 2..16
- DATA_W, 13, score width, signed two's complement
- IDX_W, 3, width of class index; must satisfy 2^IDX_W >= N_IN

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  asynchronous, active-low reset
- in_scores  input  N_IN*DATA_W  packed scores; score i = in_scores[i*DATA_W +: DATA_W] (i=0 is CNN out31, i=4 is out35)
- in_done  input  1  CNN done level; a rising edge marks scores valid
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_class  output  IDX_W  index of maximum score
- out_max  output  DATA_W  raw signed maximum score
- out_max_relu  output  DATA_W  max(out_max, 0)
- out_all_neg  output  1  every score < 0
- overrun  output  1  sticky: a frame was dropped
- frame_cnt  output  8  completed handshakes, wraps 255->0

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - out_valid, out_class, out_max, out_max_relu, out_all_neg, overrun, frame_cnt all 0.
  - Score registers 0.
  - done_d=1, so an in_done held high through reset release does NOT trigger a capture.
- Edge detect: done_d <= in_done every cycle; edge = in_done & ~done_d.
- States IDLE, SCAN, HOLD.
- IDLE:
  - On edge, register all N_IN scores (capture edge E0) and go to SCAN.
  - Set idx=0, best=most negative value (-2^(DATA_W-1)), best_idx=0, all_neg=1.
- SCAN:
  - One score per cycle, idx 0..N_IN-1.
  - Signed strict greater-than compare: if score[idx] > best, update best and best_idx.
  - Ties keep the lower index; idx 0 always wins when all scores are the minimum value.
  - all_neg &= score[idx][MSB].
  - On the edge processing idx=N_IN-1: load outputs, set out_valid=1, go to HOLD.
  - Latency: out_valid is high after edge E0+N_IN (5 cycles at default).
- HOLD:
  - out_valid=1; out_class, out_max, out_max_relu and out_all_neg are stable until handshake.
  - Handshake = out_valid & out_ready on a rising edge. On handshake: out_valid=0, frame_cnt+1 (mod 256), go to IDLE.
  - Outputs keep their last value after handshake; they are only meaningful while out_valid=1.
  - If an edge coincides with the handshake cycle: capture the new frame and go directly to SCAN, no overrun.
- Edge in SCAN, or in HOLD without handshake: frame dropped, overrun <= 1; clears only on reset.
- out_max_relu: 0 if out_max is negative, else out_max; width DATA_W, no saturation needed.
- Score inputs are sampled only at capture; changes afterwards do not affect the result.
- Reset mid-SCAN or mid-HOLD aborts immediately; no partial result is emitted.

Test Plan:
- Scores [10,200,50,199,3], edge on in_done, out_ready=1 -> out_valid high exactly 5 cycles after capture edge; class=1, max=200, max_relu=200, all_neg=0; frame_cnt=1.
- Ties [100,300,300,7,0] -> class=1, max=300.
- All negative [-5,-1,-100,-4096,-2] -> class=1, max=-1 (0x1FFF), max_relu=0, all_neg=1.
- Extremes [-4096,-4096,-4096,-4096,4095] -> class=4, max=4095.
- Backpressure: out_ready=0 for 10 cycles while in_done re-pulses in HOLD -> outputs unchanged, overrun=1. Then out_ready=1 -> single handshake, frame_cnt increments by 1. Next edge issued in the handshake cycle -> new frame processed, overrun stays 1 (sticky), no extra increment.
- Reset asserted mid-SCAN with in_done held high through release -> all outputs 0, no capture until in_done falls and rises again.
